// File: rtl/ahb_sram_slave.sv
// rtl/ahb_sram_slave.sv - AHB-Lite responder in front of a single-port synchronous SRAM
`ifndef AHB_TRANS_BITS
`define AHB_TRANS_BITS 2
`endif
`ifndef AHB_SIZE_BITS
`define AHB_SIZE_BITS 3
`endif

module ahb_sram_slave #(
   parameter int ADDR_WIDTH  = 14,
   parameter int WAIT_STATES = 0
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        HSel,
   input  logic [31:0]                 HAddress,
   input  logic [`AHB_TRANS_BITS-1:0]  HTrans,
   input  logic [`AHB_SIZE_BITS-1:0]   HSize,
   input  logic                        HWrite,
   input  logic [31:0]                 HWrite_data,
   input  logic                        HReady,
   output logic                        HReadyOut,
   output logic [1:0]                  HResp,
   output logic [31:0]                 HRead_data,
   output logic                        mem_cs,
   output logic [3:0]                  mem_we,
   output logic [ADDR_WIDTH-1:0]       mem_addr,
   output logic [31:0]                 mem_wdata,
   input  logic [31:0]                 mem_rdata
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD_WAIT, S_RD_DATA, S_ERR1, S_ERR2} state_t;

   state_t                  state, state_nxt;
   logic [3:0]              cnt, cnt_nxt;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
   logic [3:0]              be_q, be_nxt;
   logic [3:0]              be_calc;
   logic                    legal;
   logic                    accept;
   logic                    unused_addr_bits;

   assign unused_addr_bits = &{1'b0, HAddress[31:ADDR_WIDTH+2]};

   // HReadyOut is only high in IDLE or the last cycle of a data phase, so this also gates pipelining
   assign accept = HSel & HReady & HTrans[1] & HReadyOut;

   always_comb begin
      legal   = 1'b0;
      be_calc = 4'b0000;
      case (HSize)
         `AHB_SIZE_BITS'(0): begin
            legal   = 1'b1;
            be_calc = 4'b0001 << HAddress[1:0];
         end
         `AHB_SIZE_BITS'(1): begin
            legal   = ~HAddress[0];
            be_calc = HAddress[1] ? 4'b1100 : 4'b0011;
         end
         `AHB_SIZE_BITS'(2): begin
            legal   = (HAddress[1:0] == 2'b00);
            be_calc = 4'b1111;
         end
         default: begin
            legal   = 1'b0;
            be_calc = 4'b0000;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= S_IDLE;
         cnt    <= 4'd0;
         addr_q <= '0;
         be_q   <= 4'b0000;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         addr_q <= addr_nxt;
         be_q   <= be_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      addr_nxt  = addr_q;
      be_nxt    = be_q;
      case (state)
         S_IDLE:    state_nxt = S_IDLE;
         S_WR: begin
            if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else             state_nxt = S_IDLE;
         end
         S_RD_WAIT: begin
            if (cnt != 4'd0) cnt_nxt = cnt - 4'd1;
            else             state_nxt = S_RD_DATA;
         end
         S_RD_DATA: state_nxt = S_IDLE;
         S_ERR1:    state_nxt = S_ERR2;
         S_ERR2:    state_nxt = S_IDLE;
         default:   state_nxt = S_IDLE;
      endcase
      if (accept) begin
         addr_nxt = HAddress[ADDR_WIDTH+1:2];
         be_nxt   = be_calc;
         cnt_nxt  = 4'(WAIT_STATES);
         if (!legal)      state_nxt = S_ERR1;
         else if (HWrite) state_nxt = S_WR;
         else             state_nxt = S_RD_WAIT;
      end
   end

   // SRAM strobes are suppressed while rst is high so reset never causes an access
   always_comb begin
      HReadyOut  = 1'b1;
      HResp      = 2'b00;
      HRead_data = 32'h0;
      mem_cs     = 1'b0;
      mem_we     = 4'b0000;
      mem_addr   = '0;
      mem_wdata  = 32'h0;
      case (state)
         S_WR: begin
            if (cnt != 4'd0) begin
               HReadyOut = 1'b0;
            end else if (!rst) begin
               mem_cs    = 1'b1;
               mem_we    = be_q;
               mem_addr  = addr_q;
               mem_wdata = HWrite_data;
            end
         end
         S_RD_WAIT: begin
            HReadyOut = 1'b0;
            if (cnt == 4'd0 && !rst) begin
               mem_cs   = 1'b1;
               mem_addr = addr_q;
            end
         end
         S_RD_DATA: HRead_data = mem_rdata;
         S_ERR1: begin
            HReadyOut = 1'b0;
            HResp     = 2'b01;
         end
         S_ERR2:    HResp = 2'b01;
         default:   HReadyOut = 1'b1;
      endcase
   end

endmodule
